// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, fetch FSM states and the
// instruction byte-length constants used by fetch and PC-increment logic.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] LEN_1  = 4'd1;
  localparam logic [3:0] LEN_2  = 4'd2;
  localparam logic [3:0] LEN_9  = 4'd9;
  localparam logic [3:0] LEN_10 = 4'd10;

  localparam int INSTR_MAX_BYTES = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH0,
    S_FETCHN,
    S_COMPLETE
  } fetch_state_e;

endpackage

// File: rtl/instr_byte_fetcher_if.sv
// Byte-wide instruction memory read port: one request/ack handshake per byte.
interface instr_byte_fetcher_if #(
  parameter int ADDR_W = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              mem_err;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata, mem_err);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata, mem_err);
endinterface

// File: rtl/instr_len_decode.sv
// Maps an icode to the total instruction length in bytes; icodes above IPOPQ
// are flagged invalid and treated as single-byte.
module instr_len_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode_i,
  output logic [3:0] len_o,
  output logic       invalid_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    len_o     = LEN_1;
    invalid_o = 1'b0;
    case (icode_i)
      IHALT, INOP, IRET:                 len_o = LEN_1;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:      len_o = LEN_2;
      IJXX, ICALL:                       len_o = LEN_9;
      IIRMOVQ, IRMMOVQ, IMRMOVQ:         len_o = LEN_10;
      default:                           invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_byte_fetcher.sv
// Multi-cycle Y86-64 fetch front end: reads one instruction byte per memory
// handshake and assembles up to 10 bytes, byte 0 in the top octet.
module instr_byte_fetcher
  import y86_pkg::*;
#(
  parameter int MEM_SIZE = 4096,
  parameter int ADDR_W   = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    pc,
  input  logic                 pc_valid,
  output logic                 busy,
  instr_byte_fetcher_if.master mem,
  output logic [79:0]          instr_bytes,
  output logic [3:0]           instr_len,
  output logic                 done,
  output logic                 imem_error,
  output logic                 instr_invalid
);

  localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_SIZE);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        idx_q, idx_d;
  logic [79:0]       bytes_q, bytes_d;
  logic [3:0]        len_q, len_d;
  logic              err_q, err_d;
  logic              inv_q, inv_d;

  logic [ADDR_W:0]   addr_wide;
  logic              addr_oob;
  logic              fetching;
  logic              take;
  logic [3:0]        dec_len;
  logic              dec_inv;

  // One extra bit keeps a wrap past 2^ADDR_W visible as out of range.
  assign addr_wide = {1'b0, base_q} + (ADDR_W+1)'(idx_q);
  assign addr_oob  = (addr_wide >= ADDR_LIMIT);
  assign fetching  = (state_q == S_FETCH0) || (state_q == S_FETCHN);

  assign mem.mem_req  = fetching && !addr_oob;
  assign mem.mem_addr = addr_wide[ADDR_W-1:0];
  assign take         = mem.mem_req && mem.mem_ack;

  instr_len_decode u_len_decode (
    .icode_i   (mem.mem_rdata[7:4]),
    .len_o     (dec_len),
    .invalid_o (dec_inv)
  );

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    idx_d   = idx_q;
    bytes_d = bytes_q;
    len_d   = len_q;
    err_d   = err_q;
    inv_d   = inv_q;

    case (state_q)
      S_IDLE: begin
        if (pc_valid) begin
          base_d  = pc;
          idx_d   = 4'd0;
          bytes_d = '0;
          err_d   = 1'b0;
          inv_d   = 1'b0;
          state_d = S_FETCH0;
        end
      end

      S_FETCH0: begin
        if (addr_oob) begin
          err_d   = 1'b1;
          len_d   = LEN_1;
          state_d = S_COMPLETE;
        end else if (take) begin
          if (mem.mem_err) begin
            err_d   = 1'b1;
            len_d   = LEN_1;
            state_d = S_COMPLETE;
          end else begin
            bytes_d[79:72] = mem.mem_rdata;
            len_d          = dec_len;
            inv_d          = dec_inv;
            if (dec_len == LEN_1) begin
              state_d = S_COMPLETE;
            end else begin
              idx_d   = 4'd1;
              state_d = S_FETCHN;
            end
          end
        end
      end

      S_FETCHN: begin
        if (addr_oob) begin
          err_d   = 1'b1;
          state_d = S_COMPLETE;
        end else if (take) begin
          if (mem.mem_err) begin
            err_d   = 1'b1;
            state_d = S_COMPLETE;
          end else begin
            for (int i = 1; i < INSTR_MAX_BYTES; i++) begin
              if (idx_q == 4'(i)) bytes_d[(INSTR_MAX_BYTES-1-i)*8 +: 8] = mem.mem_rdata;
            end
            idx_d = idx_q + 4'd1;
            if (idx_q + 4'd1 == len_q) state_d = S_COMPLETE;
          end
        end
      end

      S_COMPLETE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      bytes_q <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      bytes_q <= bytes_d;
      len_q   <= len_d;
      err_q   <= err_d;
      inv_q   <= inv_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_COMPLETE);
  assign instr_bytes   = bytes_q;
  assign instr_len     = len_q;
  assign imem_error    = err_q;
  assign instr_invalid = inv_q;

endmodule

// File: tb/tb_instr_byte_fetcher.sv
// Directed bench for instr_byte_fetcher: byte memory model with configurable
// wait states and fault injection, hand-computed expected results.
module tb_instr_byte_fetcher;

  localparam int ADDR_W   = 64;
  localparam int MEM_SIZE = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [ADDR_W-1:0] pc = '0;
  logic              pc_valid = 1'b0;
  logic              busy;
  logic [79:0]       instr_bytes;
  logic [3:0]        instr_len;
  logic              done;
  logic              imem_error;
  logic              instr_invalid;

  instr_byte_fetcher_if #(.ADDR_W(ADDR_W)) mem_bus ();

  instr_byte_fetcher #(.MEM_SIZE(MEM_SIZE), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .pc_valid      (pc_valid),
    .busy          (busy),
    .mem           (mem_bus.master),
    .instr_bytes   (instr_bytes),
    .instr_len     (instr_len),
    .done          (done),
    .imem_error    (imem_error),
    .instr_invalid (instr_invalid)
  );

  always #5 clk = ~clk;

  // Memory model
  logic [7:0]        mem [0:MEM_SIZE-1];
  int                wait_states = 0;
  int                wait_cnt = 0;
  bit                err_en = 1'b0;
  logic [ADDR_W-1:0] err_addr = '0;

  assign mem_bus.mem_ack   = mem_bus.mem_req && (wait_cnt >= wait_states);
  assign mem_bus.mem_rdata = (mem_bus.mem_addr < 64'(MEM_SIZE)) ? mem[mem_bus.mem_addr[11:0]] : 8'hEE;
  assign mem_bus.mem_err   = mem_bus.mem_ack && err_en && (mem_bus.mem_addr == err_addr);

  always @(posedge clk) wait_cnt <= (mem_bus.mem_req && !mem_bus.mem_ack) ? wait_cnt + 1 : 0;

  // Bus observation
  logic [ADDR_W-1:0] ack_q[$];
  int                req_cycles = 0;
  int                done_cnt = 0;
  bit                oob_req = 1'b0;

  always @(negedge clk) begin
    if (mem_bus.mem_req) begin
      req_cycles++;
      if (mem_bus.mem_addr >= 64'(MEM_SIZE)) oob_req = 1'b1;
      if (mem_bus.mem_ack) ack_q.push_back(mem_bus.mem_addr);
    end
    if (done) done_cnt++;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_obs();
    ack_q.delete();
    req_cycles = 0;
    done_cnt   = 0;
    oob_req    = 1'b0;
  endtask

  // Issues one fetch and waits for done; lat counts cycles after the pc_valid
  // cycle. When poke is set a second pc_valid is driven while busy.
  task automatic do_fetch(input string tag, input logic [ADDR_W-1:0] a, input int ws,
                          input bit poke, output int lat);
    bit seen;
    wait_states = ws;
    seen = 1'b0;
    @(negedge clk);
    clear_obs();
    pc       = a;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 300; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (poke && lat == 3) begin
        pc       = '0;
        pc_valid = 1'b1;
      end else begin
        pc_valid = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    pc_valid = 1'b0;
    if (!seen) check({tag, "_timeout"}, 80'd0, 80'd1);
    repeat (3) @(negedge clk);
    #1;
  endtask

  int lat;

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'h00;
    mem[0] = 8'h10;
    mem[8] = 8'hC0;
    begin
      logic [7:0] irm [10];
      irm = '{8'h30, 8'hF2, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
      for (int i = 0; i < 10; i++) mem[12'h100 + i] = irm[i];
    end
    begin
      logic [7:0] rmm [6];
      rmm = '{8'h40, 8'h15, 8'h11, 8'h22, 8'h33, 8'h44};
      for (int i = 0; i < 6; i++) mem[4090 + i] = rmm[i];
    end
    begin
      logic [7:0] cl [9];
      cl = '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 9; i++) mem[12'h200 + i] = cl[i];
    end

    // Reset state
    #12;
    check("rst_busy", 80'(busy), 80'd0);
    check("rst_req", 80'(mem_bus.mem_req), 80'd0);
    check("rst_done", 80'(done), 80'd0);
    check("rst_bytes", instr_bytes, 80'd0);
    check("rst_len", 80'(instr_len), 80'd0);
    check("rst_err", 80'(imem_error), 80'd0);
    check("rst_inv", 80'(instr_invalid), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // nop at 0, zero wait states
    do_fetch("nop", 64'h0, 0, 1'b0, lat);
    check("nop_latency", 80'(lat), 80'd2);
    check("nop_len", 80'(instr_len), 80'd1);
    check("nop_bytes", instr_bytes, 80'h10000000000000000000);
    check("nop_err", 80'(imem_error), 80'd0);
    check("nop_req_cycles", 80'(req_cycles), 80'd1);
    check("nop_done_cnt", 80'(done_cnt), 80'd1);
    check("nop_idle", 80'(busy), 80'd0);

    // irmovq at 0x100, two wait states per byte
    do_fetch("irm", 64'h100, 2, 1'b0, lat);
    check("irm_acks", 80'(ack_q.size()), 80'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < ack_q.size()) check($sformatf("irm_addr%0d", i), 80'(ack_q[i]), 80'(64'h100 + 64'(i)));
    end
    check("irm_len", 80'(instr_len), 80'd10);
    check("irm_bytes", instr_bytes, 80'h30F20807060504030201);
    check("irm_err", 80'(imem_error), 80'd0);
    check("irm_inv", 80'(instr_invalid), 80'd0);

    // rmmovq crossing the end of memory
    do_fetch("oob", 64'd4090, 0, 1'b0, lat);
    check("oob_acks", 80'(ack_q.size()), 80'd6);
    check("oob_no_req_4096", 80'(oob_req), 80'd0);
    check("oob_err", 80'(imem_error), 80'd1);
    check("oob_len", 80'(instr_len), 80'd10);
    check("oob_bytes", instr_bytes, 80'h40151122334400000000);
    check("oob_done_cnt", 80'(done_cnt), 80'd1);

    // invalid icode
    do_fetch("inv", 64'd8, 0, 1'b0, lat);
    check("inv_flag", 80'(instr_invalid), 80'd1);
    check("inv_len", 80'(instr_len), 80'd1);
    check("inv_bytes", instr_bytes, 80'hC0000000000000000000);
    check("inv_req_cycles", 80'(req_cycles), 80'd1);
    check("inv_err", 80'(imem_error), 80'd0);
    check("inv_done_cnt", 80'(done_cnt), 80'd1);

    // call with a fault on byte 3
    err_en   = 1'b1;
    err_addr = 64'h203;
    do_fetch("call", 64'h200, 0, 1'b0, lat);
    err_en   = 1'b0;
    check("call_err", 80'(imem_error), 80'd1);
    check("call_len", 80'(instr_len), 80'd9);
    check("call_bytes", instr_bytes, 80'h80112200000000000000);
    check("call_req_cycles", 80'(req_cycles), 80'd4);
    check("call_inv", 80'(instr_invalid), 80'd0);

    // async reset mid-FETCHN
    wait_states = 1;
    @(negedge clk);
    clear_obs();
    pc       = 64'h100;
    pc_valid = 1'b1;
    @(negedge clk);
    pc_valid = 1'b0;
    for (int c = 0; c < 50 && ack_q.size() < 3; c++) @(negedge clk);
    check("mid_reached", 80'(ack_q.size() >= 3), 80'd1);
    #2;
    check("mid_busy", 80'(busy), 80'd1);
    rst_n = 1'b0;
    #1;
    check("mid_req_drop", 80'(mem_bus.mem_req), 80'd0);
    check("mid_busy_drop", 80'(busy), 80'd0);
    check("mid_bytes", instr_bytes, 80'd0);
    check("mid_len", 80'(instr_len), 80'd0);
    check("mid_err", 80'(imem_error), 80'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    repeat (4) @(negedge clk);
    #1;
    check("mid_no_done", 80'(done_cnt), 80'd0);
    check("mid_no_req", 80'(req_cycles), 80'd0);

    // clean refetch with a dropped pc_valid while busy
    do_fetch("refetch", 64'h100, 0, 1'b1, lat);
    check("re_latency", 80'(lat), 80'd11);
    check("re_bytes", instr_bytes, 80'h30F20807060504030201);
    check("re_len", 80'(instr_len), 80'd10);
    check("re_req_cycles", 80'(req_cycles), 80'd10);
    check("re_done_cnt", 80'(done_cnt), 80'd1);
    check("re_err", 80'(imem_error), 80'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_byte_fetcher.md
Name: instr_byte_fetcher

Overview:
Multi-cycle fetch front end for the sequential Y86-64 core. It reads one instruction from byte-wide instruction memory, one byte per handshake, starting at a given PC. It decodes the instruction length from byte 0 and assembles up to 10 bytes into one 80-bit word. That word feeds the split/align/PC-increment logic downstream: byte 0 drives icode/ifun, and bytes 1..9 drive rA/rB/valC.

Parameters:
MEM_SIZE, 4096, instruction memory size in bytes; valid addresses are 0..MEM_SIZE-1
ADDR_W, 64, width of PC and memory address

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc  in  ADDR_W  start address, sampled when pc_valid=1 in IDLE
pc_valid  in  1  start request; ignored while busy=1
busy  out  1  high in every state except IDLE
mem_req  out  1  byte read request
mem_addr  out  ADDR_W  byte address, stable while mem_req=1
mem_ack  in  1  read completes this cycle; mem_rdata is valid
mem_rdata  in  8  returned byte
mem_err  in  1  qualified by mem_ack; the access faulted
instr_bytes  out  80  [79:72]=byte0, [71:64]=byte1, ..., [7:0]=byte9; unfetched bytes are 0
instr_len  out  4  1, 2, 9 or 10
done  out  1  one-cycle pulse; all outputs valid
imem_error  out  1  fetch aborted (address range or mem_err); held with outputs
instr_invalid  out  1  icode > 4'hB; held with outputs

Behaviour:
- Reset (async, rst_n=0):
  - Go to IDLE.
  - All outputs go to 0, including mem_req, which drops immediately.
  - A partial fetch is discarded. No memory request is issued until a new pc_valid.
- States: IDLE, FETCH0, FETCHN, COMPLETE.
- IDLE:
  - On pc_valid: capture pc as base, set idx=0, clear instr_bytes, imem_error and instr_invalid, then go to FETCH0.
  - instr_bytes, instr_len and the flags hold their last completed values until the next capture.
- Address computation:
  - mem_addr = base + idx, modulo 2^ADDR_W.
  - Range check: if base+idx >= MEM_SIZE, compare at ADDR_W+1 bits so that wrap counts as out of range. In that case:
    - mem_req is not asserted;
    - set imem_error=1;
    - go to COMPLETE on the next edge.
- FETCH0:
  - mem_req=1 until mem_ack. On mem_ack, load byte0 and decode the length from icode=byte0[7:4]:
    - 0 or 1 or 9 -> 1
    - 2, 6, A, B -> 2
    - 7, 8 -> 9
    - 3, 4, 5 -> 10
    - C..F -> 1, with instr_invalid=1
  - If mem_err: set imem_error=1 and instr_len=1, then go to COMPLETE.
  - Else if len=1: go to COMPLETE.
  - Else: set idx=1 and go to FETCHN.
- FETCHN:
  - mem_req=1. On mem_ack, write the byte into slot idx and increment idx.
  - If mem_err: set imem_error, keep instr_len as decoded, leave remaining bytes at 0, go to COMPLETE.
  - If idx+1 == len: go to COMPLETE.
- mem_req and mem_addr:
  - mem_req deasserts in the cycle after the final ack of a fetch.
  - Between bytes, mem_req stays high and mem_addr advances on the edge after each ack.
  - mem_ack while mem_req=0 is ignored.
- COMPLETE: done=1 for exactly one cycle, then go to IDLE. A pc_valid seen during COMPLETE is ignored.
- Latency: with a zero-wait-state memory (ack in the same cycle as req), an N-byte instruction has done high N+1 cycles after the pc_valid cycle.
- Simultaneous events: pc_valid while busy is dropped, not queued.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: IHALT..IPOPQ = 4'h0..4'hB;
  - the fetch FSM state enum;
  - the byte-length constants 1/2/9/10.
- One combinational sub-module, instr_len_decode (icode -> len[3:0], invalid), reused by downstream PC-increment logic.

Test Plan:
- nop at pc=0 (byte 0x10), zero-wait memory -> instr_len=1, instr_bytes=0x10 followed by 72 zero bits, done 2 cycles after pc_valid, one mem_req cycle.
- irmovq at pc=0x100, bytes 30 F2 08 07 06 05 04 03 02 01, acks with 2 wait states each -> addresses 0x100..0x109 in order, instr_len=10, instr_bytes=0x30F20807060504030201, imem_error=0.
- rmmovq at pc=4090 (MEM_SIZE=4096) -> 6 bytes fetched (4090..4095), no request to 4096, imem_error=1, done pulse, bytes 6..9 = 0.
- Byte 0xC0 at pc=8 -> instr_invalid=1, instr_len=1, single request, done pulse.
- call (0x80) where mem_err accompanies the ack of byte 3 -> imem_error=1, instr_len=9, bytes 3..8 = 0, no further requests.
- rst_n pulsed low mid-FETCHN of an irmovq -> mem_req falls asynchronously, all outputs 0, no done. A following pc_valid refetches cleanly. A pc_valid asserted while busy causes no second fetch.
